// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a show-ahead frame FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ovs #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       baud_tick,
  input  logic                       rxd,
  input  logic                       parity_odd,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_perr,
  output logic                       out_ferr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int TW = $clog2(OVS);
  localparam int IW = $clog2(DATA_W);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic par_err(input logic [DATA_W-1:0] d, input logic b, input logic odd);
    return (^d ^ b) != odd;
  endfunction

  state_t            state, state_n;
  logic [1:0]        sync;
  logic              rxs;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic              sidx, sidx_n;
  logic              ferr_r, ferr_n;
  logic              perr_r, perr_n;
  logic              armed;
  logic              shift_en, push;
  logic              half_pt, full_pt;
  logic [DATA_W-1:0] shreg;

  logic [FW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     head;
  logic              full, pop, wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rxd};
  end
  assign rxs = sync[1];

  assign half_pt = baud_tick && (tcnt == TW'(OVS/2 - 1));
  assign full_pt = baud_tick && (tcnt == TW'(OVS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tcnt   <= '0;
      idx    <= '0;
      sidx   <= 1'b0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      idx    <= idx_n;
      sidx   <= sidx_n;
      ferr_r <= ferr_n;
      perr_r <= perr_n;
    end
  end

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    idx_n    = idx;
    sidx_n   = sidx;
    ferr_n   = ferr_r;
    perr_n   = perr_r;
    shift_en = 1'b0;
    push     = 1'b0;
    if (baud_tick) tcnt_n = tcnt + 1'b1;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        // armed blocks a held-low (break) line from retriggering frames
        if (baud_tick && !rxs && armed) state_n = START;
      end
      START: if (half_pt) begin
        tcnt_n  = '0;
        idx_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (full_pt) begin
        tcnt_n   = '0;
        shift_en = 1'b1;
        if (idx == IW'(DATA_W - 1)) begin
          sidx_n = 1'b0;
          ferr_n = 1'b0;
          perr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          idx_n = idx + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (full_pt) begin
        tcnt_n  = '0;
        perr_n  = par_err(shreg, rxs, parity_odd);
        state_n = STOP;
      end
`endif
      STOP: if (full_pt) begin
        tcnt_n = '0;
        if (!rxs) ferr_n = 1'b1;
        if (sidx == 1'(STOP_BITS - 1)) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          sidx_n = sidx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifndef UART_RX_PARITY_EN
  logic unused_parity;
  assign unused_parity = parity_odd ^ perr_r ^ par_err(shreg, 1'b0, 1'b0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                armed <= 1'b1;
    else if (push && ferr_n)   armed <= 1'b0;
    else if (rxs)              armed <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg[idx] <= rxs;
  end

  // ---- frame FIFO ----
  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk) begin
`ifdef UART_RX_PARITY_EN
    if (wr_en) mem[wr_ptr] <= {ferr_n, perr_n, shreg};
`else
    if (wr_en) mem[wr_ptr] <= {ferr_n, 1'b0, shreg};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      level <= level + 1'b1;
      else if (pop && !wr_en) level <= level - 1'b1;
    end
  end

  // Head is gated so stale, unreset storage never shows while empty.
  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[DATA_W-1:0] : '0;
  assign out_perr = out_valid ? head[DATA_W]     : 1'b0;
  assign out_ferr = out_valid ? head[DATA_W+1]   : 1'b0;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: vector table, hand-written corner sequences and a randomized phase.
module tb_uart_rx_ovs;
  localparam int DATA_W = 8, OVS = 16, STOP_BITS = 1, DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0, rst_n, baud_tick, rxd, parity_odd, out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_perr, out_ferr, out_valid, overrun;
  logic [$clog2(DEPTH):0] level;

  uart_rx_ovs #(.DATA_W(DATA_W), .OVS(OVS), .STOP_BITS(STOP_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rxd(rxd), .parity_odd(parity_odd),
    .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .level(level));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, ovr_cnt = 0;
  int tick_div = 1, tick_ph = 0;
  bit mon_en = 0, rand_rdy = 0;

  typedef struct { logic [7:0] d; logic perr; logic ferr; } frm_t;
  frm_t exp_q[$];

  typedef struct {
    logic [7:0] d; logic pbit; logic stopv; logic podd;
    logic [7:0] exp_d; logic exp_perr; logic exp_ferr;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Oversample tick generator; value changes just after each edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick_ph = tick_ph + 1;
      if (tick_ph >= tick_div) tick_ph = 0;
      baud_tick = (tick_ph == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rnd_unexpected: got frame %0h expected none", out_data);
      end else begin
        check("rnd_data", out_data, exp_q[0].d);
        check("rnd_perr", out_perr, exp_q[0].perr);
        check("rnd_ferr", out_ferr, exp_q[0].ferr);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic hold_bit(input logic b);
    int n = 0, cyc = 0;
    #1 rxd = b;
    while (n < OVS) begin
      @(posedge clk);
      if (baud_tick) n++;
      cyc++;
      if (cyc > 2000) begin
        $display("FAIL tick_timeout: got %0d ticks expected %0d", n, OVS);
        $fatal(1, "no baud ticks");
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopv);
    hold_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) hold_bit(d[i]);
    if (PEN) hold_bit(pbit);
    for (int s = 0; s < STOP_BITS; s++) hold_bit(stopv);
    hold_bit(1'b1);
    hold_bit(1'b1);
    @(negedge clk);
  endtask

  task automatic pop_one();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rxd = 1'b1; parity_odd = 1'b0; out_ready = 1'b0;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0); check("rst_level", level, 0);
    check("rst_data", out_data, 0);   check("rst_perr", out_perr, 0);
    check("rst_ferr", out_ferr, 0);   check("rst_overrun", overrun, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    hold_bit(1'b1);

    for (int v = 0; v < 5; v++) begin
      parity_odd = vecs[v].podd;
      send_frame(vecs[v].d, vecs[v].pbit, vecs[v].stopv);
      check($sformatf("vec%0d_level", v), level, 1);
      check($sformatf("vec%0d_data", v), out_data, vecs[v].exp_d);
      check($sformatf("vec%0d_perr", v), out_perr, PEN ? vecs[v].exp_perr : 1'b0);
      check($sformatf("vec%0d_ferr", v), out_ferr, vecs[v].exp_ferr);
      pop_one();
      check($sformatf("vec%0d_empty", v), out_valid, 0);
    end
    parity_odd = 1'b0;

    // Start glitch of 4 ticks must be rejected.
    #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    hold_bit(1'b1); hold_bit(1'b1);
    @(negedge clk);
    check("glitch_level", level, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("post_glitch_data", out_data, 8'h5A);
    check("post_glitch_level", level, 1);
    pop_one();

    // Break: line held low well beyond one frame.
    for (int i = 0; i < 1 + DATA_W + 1 + STOP_BITS + 4; i++) hold_bit(1'b0);
    @(negedge clk);
    check("break_level", level, 1);
    check("break_data", out_data, 0);
    check("break_ferr", out_ferr, 1);
    check("break_perr", out_perr, 0);
    hold_bit(1'b1); hold_bit(1'b1);
    @(negedge clk);
    check("break_no_more", level, 1);
    pop_one();

    // Overflow with consumer stalled.
    ovr_cnt = 0;
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), ^8'(i), 1'b1);
    check("ovf_level", level, DEPTH);
    check("ovf_pulses", ovr_cnt, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_data", i), out_data, i);
      pop_one();
    end
    check("drain_empty", out_valid, 0);

    // Reset mid-DATA with two frames buffered.
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    check("pre_rst_level", level, 2);
    hold_bit(1'b0); hold_bit(1'b1); hold_bit(1'b0);
    #1 rst_n = 1'b0; rxd = 1'b1;
    @(negedge clk);
    check("midrst_level", level, 0);   check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0); check("midrst_overrun", overrun, 0);
    check("midrst_ferr", out_ferr, 0); check("midrst_perr", out_perr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    hold_bit(1'b1); hold_bit(1'b1);
    send_frame(8'h81, ^8'h81, 1'b1);
    check("postrst_level", level, 1);
    check("postrst_data", out_data, 8'h81);
    pop_one();

    // Randomized frames against the queue model.
    ovr_cnt = 0; mon_en = 1; rand_rdy = 1;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] d; logic podd, pbit, stopv;
      frm_t e;
      d = 8'($urandom);
      podd = 1'($urandom_range(0, 1));
      pbit = (^d) ^ podd ^ ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 4) != 0);
      tick_div = $urandom_range(1, 3);
      e.d = d;
      e.perr = PEN ? (((^d) ^ pbit) != podd) : 1'b0;
      e.ferr = !stopv;
      exp_q.push_back(e);
      parity_odd = podd;
      send_frame(d, pbit, stopv);
    end
    for (int w = 0; w < 400 && exp_q.size() != 0; w++) @(negedge clk);
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_no_overrun", ovr_cnt, 0);
    rand_rdy = 0; mon_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
